fmultiplier: RTL and testbench
==============================

FMULTIPLIER -- requirements
Module: fmultiplier

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The module SHALL have these ports, in positional order out, a, b, clk, rst_n.
REQ-003 clk  input  1  rising-edge clock for all pipeline registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  32  IEEE-754 single-precision operand.
REQ-006 b  input  32  IEEE-754 single-precision operand.
REQ-007 out  output  32  IEEE-754 single-precision product a*b, driven from a register.
REQ-008 The module SHALL have no parameters and no valid/ready handshake.

Function
REQ-009 The datapath SHALL be a 3-stage pipeline with one new operand pair accepted every cycle (throughput 1/cycle).
REQ-010 Stage 1 SHALL capture, on capture edge k:
- unpacked fields
- sign = a[31]^b[31]
- biased exponent sum minus 127
- special-case classification
REQ-011 Stage 2 SHALL form the 48-bit product of the two 24-bit significands (hidden bit included).
REQ-012 Stage 3 SHALL do the following and register the result into out:
- normalize (shift right 1 and increment exponent if product bit 47 is set)
- round to nearest, ties to even, using guard/round/sticky bits
- renormalize on rounding carry
- pack the result
REQ-013 For a and b stable before capture edge k, out SHALL show a*b after edge k+2 and stay valid for one cycle per pair.
REQ-014 Denormal inputs (exp=0, frac≠0) SHALL be treated as signed zero (flush-to-zero).
REQ-015 Special-case priority, checked in this order:
- either operand NaN (exp=255, frac≠0) -> 0x7FC00000
- infinity times zero -> 0x7FC00000
- either operand infinite -> {sign,8'hFF,23'h0}
- either operand zero -> {sign,31'h0}
REQ-016 A final biased exponent ≥255 after rounding SHALL produce {sign,8'hFF,23'h0} (overflow to infinity).
REQ-017 A final biased exponent ≤0 SHALL produce {sign,31'h0} (underflow flushes to zero; no denormal output).
REQ-018 Exponent arithmetic SHALL use at least 10-bit signed width so that overflow and underflow are detected without wrap-around.
REQ-019 Changing the inputs every cycle SHALL NOT corrupt in-flight results; each result depends only on its own captured operands.

Reset
REQ-020 While rst_n=0, out and all pipeline registers SHALL be 0x00000000, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard in-flight results.
REQ-022 After rst_n deasserts, out SHALL hold 0 until the first captured pair reaches it, at the third rising edge counting the capture edge.

Verification
REQ-023 a=0x4348C000 (200.75), b=0x7F800000 (+inf) -> out=0x7F800000 after 3 edges.
REQ-024 a=0x411C0000 (9.75), b=0x3F100000 (0.5625) -> out=0x40AF8000 (5.484375).
REQ-025 a=0x41480000 (12.5), b=0xC0B20000 (-5.5625) -> out=0xC28B1000 (-69.53125).
REQ-026 NaN and invalid cases:
- a=0x41480000, b=0x7F800001 -> out=0x7FC00000
- a=0x00000000, b=0x7F800000 -> out=0x7FC00000
REQ-027 a=0x00000000, b=0x40A00000 (5.0) -> out=0x00000000.
REQ-028 Pipeline, overflow and reset checks:
- Back-to-back pairs applied on consecutive edges (REQ-023 to REQ-027 sequence) -> outputs appear on consecutive cycles in the same order.
- a=b=0x7F000000 -> out=0x7F800000.
- rst_n pulsed low mid-stream -> out=0 immediately.

Source files
------------

// File: rtl/fmultiplier.sv
// Three-stage IEEE-754 single-precision multiplier, one operand pair per cycle.
// Denormal inputs are flushed to zero; results are never denormal.
module fmultiplier (
    output logic [31:0] out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clk,
    input  logic        rst_n
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, exponent sum
    // ------------------------------------------------------------------
    logic [7:0]        exp_a;
    logic [7:0]        exp_b;
    logic [22:0]       frac_a;
    logic [22:0]       frac_b;
    logic              nan_a;
    logic              nan_b;
    logic              inf_a;
    logic              inf_b;
    logic              zero_a;
    logic              zero_b;
    logic              sign_c;
    logic signed [9:0] exp_sum_c;
    logic              special_c;
    logic [31:0]       special_val_c;
    logic [23:0]       mant_a_c;
    logic [23:0]       mant_b_c;

    always_comb begin
        exp_a  = a[30:23];
        exp_b  = b[30:23];
        frac_a = a[22:0];
        frac_b = b[22:0];
        nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
        nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
        inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
        inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
        // Exponent zero covers both true zero and flushed denormals.
        zero_a = (exp_a == 8'h00);
        zero_b = (exp_b == 8'h00);
        sign_c = a[31] ^ b[31];

        exp_sum_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

        special_c     = 1'b1;
        special_val_c = 32'd0;
        if (nan_a || nan_b) begin
            special_val_c = QNAN;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            special_val_c = QNAN;
        end else if (inf_a || inf_b) begin
            special_val_c = {sign_c, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            special_val_c = {sign_c, 31'd0};
        end else begin
            special_c = 1'b0;
        end

        // Special results bypass the datapath, so keep the multiplier quiet.
        mant_a_c = special_c ? 24'd0 : {1'b1, frac_a};
        mant_b_c = special_c ? 24'd0 : {1'b1, frac_b};
    end

    logic              s1_sign;
    logic signed [9:0] s1_exp;
    logic [23:0]       s1_mant_a;
    logic [23:0]       s1_mant_b;
    logic              s1_special;
    logic [31:0]       s1_special_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign        <= 1'b0;
            s1_exp         <= 10'sd0;
            s1_mant_a      <= 24'd0;
            s1_mant_b      <= 24'd0;
            s1_special     <= 1'b0;
            s1_special_val <= 32'd0;
        end else begin
            s1_sign        <= sign_c;
            s1_exp         <= exp_sum_c;
            s1_mant_a      <= mant_a_c;
            s1_mant_b      <= mant_b_c;
            s1_special     <= special_c;
            s1_special_val <= special_val_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand product
    // ------------------------------------------------------------------
    logic              s2_sign;
    logic signed [9:0] s2_exp;
    logic [47:0]       s2_prod;
    logic              s2_special;
    logic [31:0]       s2_special_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign        <= 1'b0;
            s2_exp         <= 10'sd0;
            s2_prod        <= 48'd0;
            s2_special     <= 1'b0;
            s2_special_val <= 32'd0;
        end else begin
            s2_sign        <= s1_sign;
            s2_exp         <= s1_exp;
            s2_prod        <= s1_mant_a * s1_mant_b;
            s2_special     <= s1_special;
            s2_special_val <= s1_special_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize, round to nearest even, pack
    // ------------------------------------------------------------------
    logic [22:0]       norm_frac;
    logic              guard_bit;
    logic              round_bit;
    logic              sticky_bit;
    logic signed [9:0] norm_exp;
    logic              round_up;
    logic [24:0]       mant_rnd;
    logic signed [9:0] final_exp;
    logic [22:0]       final_frac;
    logic [31:0]       result_c;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); bit 47 marks [2,4).
        if (s2_prod[47]) begin
            norm_frac  = s2_prod[46:24];
            guard_bit  = s2_prod[23];
            round_bit  = s2_prod[22];
            sticky_bit = |s2_prod[21:0];
            norm_exp   = s2_exp + 10'sd1;
        end else begin
            norm_frac  = s2_prod[45:23];
            guard_bit  = s2_prod[22];
            round_bit  = s2_prod[21];
            sticky_bit = |s2_prod[20:0];
            norm_exp   = s2_exp;
        end

        round_up = guard_bit && (round_bit || sticky_bit || norm_frac[0]);
        mant_rnd = {2'b01, norm_frac} + {24'd0, round_up};

        // Rounding 1.111..1 up yields 10.000..0: shift once more.
        if (mant_rnd[24]) begin
            final_exp  = norm_exp + 10'sd1;
            final_frac = mant_rnd[23:1];
        end else begin
            final_exp  = norm_exp;
            final_frac = mant_rnd[22:0];
        end

        if (s2_special) begin
            result_c = s2_special_val;
        end else if (final_exp >= 10'sd255) begin
            result_c = {s2_sign, 8'hFF, 23'd0};
        end else if (final_exp <= 10'sd0) begin
            result_c = {s2_sign, 31'd0};
        end else begin
            result_c = {s2_sign, final_exp[7:0], final_frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 32'd0;
        end else begin
            out <= result_c;
        end
    end

endmodule

// File: tb/tb_fmultiplier.sv
// Directed-vector bench for fmultiplier: streams operand pairs back to back,
// checks each product two edges after capture, and exercises async reset.
module tb_fmultiplier;

    logic [31:0] out;
    logic [31:0] a;
    logic [31:0] b;
    logic        clk;
    logic        rst_n;

    fmultiplier dut (
        .out   (out),
        .a     (a),
        .b     (b),
        .clk   (clk),
        .rst_n (rst_n)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors: a, b, hand-computed product ----------------
    localparam int NVEC = 22;
    logic [31:0] vec_a [NVEC];
    logic [31:0] vec_b [NVEC];
    logic [31:0] vec_p [NVEC];

    initial begin
        vec_a[0]  = 32'h4348C000; vec_b[0]  = 32'h7F800000; vec_p[0]  = 32'h7F800000; // 200.75 * +inf
        vec_a[1]  = 32'h411C0000; vec_b[1]  = 32'h3F100000; vec_p[1]  = 32'h40AF8000; // 9.75 * 0.5625
        vec_a[2]  = 32'h41480000; vec_b[2]  = 32'hC0B20000; vec_p[2]  = 32'hC28B1000; // 12.5 * -5.5625
        vec_a[3]  = 32'h41480000; vec_b[3]  = 32'h7F800001; vec_p[3]  = 32'h7FC00000; // x * NaN
        vec_a[4]  = 32'h00000000; vec_b[4]  = 32'h7F800000; vec_p[4]  = 32'h7FC00000; // 0 * inf
        vec_a[5]  = 32'h00000000; vec_b[5]  = 32'h40A00000; vec_p[5]  = 32'h00000000; // 0 * 5
        vec_a[6]  = 32'h7F000000; vec_b[6]  = 32'h7F000000; vec_p[6]  = 32'h7F800000; // overflow
        vec_a[7]  = 32'h3F800000; vec_b[7]  = 32'h3F800000; vec_p[7]  = 32'h3F800000; // 1 * 1
        vec_a[8]  = 32'h3F800003; vec_b[8]  = 32'h3FC00000; vec_p[8]  = 32'h3FC00004; // tie, stays even
        vec_a[9]  = 32'h40400000; vec_b[9]  = 32'h3F800001; vec_p[9]  = 32'h40400002; // tie, rounds to even
        vec_a[10] = 32'h3FFFFFFE; vec_b[10] = 32'h3F800001; vec_p[10] = 32'h40000000; // rounding carry
        vec_a[11] = 32'h7F7FFFFF; vec_b[11] = 32'h3F800001; vec_p[11] = 32'h7F800000; // overflow via normalize
        vec_a[12] = 32'h00800000; vec_b[12] = 32'h00800000; vec_p[12] = 32'h00000000; // underflow
        vec_a[13] = 32'h80800000; vec_b[13] = 32'h00800000; vec_p[13] = 32'h80000000; // signed underflow
        vec_a[14] = 32'h00800000; vec_b[14] = 32'h3F800000; vec_p[14] = 32'h00800000; // exponent exactly 1
        vec_a[15] = 32'h00800000; vec_b[15] = 32'h3F000000; vec_p[15] = 32'h00000000; // exponent exactly 0
        vec_a[16] = 32'h80000001; vec_b[16] = 32'h40000000; vec_p[16] = 32'h80000000; // denormal flush
        vec_a[17] = 32'hFF800000; vec_b[17] = 32'h40000000; vec_p[17] = 32'hFF800000; // -inf * 2
        vec_a[18] = 32'h7FC00000; vec_b[18] = 32'h00000000; vec_p[18] = 32'h7FC00000; // NaN beats zero
        vec_a[19] = 32'h7F800000; vec_b[19] = 32'h00000001; vec_p[19] = 32'h7FC00000; // inf * denormal
        vec_a[20] = 32'hC0000000; vec_b[20] = 32'hC0400000; vec_p[20] = 32'h40C00000; // -2 * -3
        vec_a[21] = 32'h7F000000; vec_b[21] = 32'h3F800000; vec_p[21] = 32'h7F000000; // exponent 254
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q [$];
    int          tag_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, expv);
        end
    endtask

    // Drive vectors [first..last] on consecutive edges; each product is due two
    // edges after its capture edge. With hold_zero, out must stay 0 until then.
    task automatic run_vectors(input int first, input int last, input bit hold_zero);
        int n_drv;
        n_drv = last - first + 1;
        for (int n = 0; n < n_drv + 2; n++) begin
            if (n < n_drv) begin
                a = vec_a[first + n];
                b = vec_b[first + n];
                exp_q.push_back(vec_p[first + n]);
                tag_q.push_back(first + n);
            end
            @(posedge clk);
            #1;
            if (n >= 2) begin
                check($sformatf("vec%0d", tag_q.pop_front()), out, exp_q.pop_front());
            end else if (hold_zero) begin
                check($sformatf("hold_zero_e%0d", n), out, 32'd0);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        #2;
        check("reset_no_clk", out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_clocked", out, 32'd0);

        rst_n = 1'b1;
        run_vectors(0, 5, 1'b1);
        run_vectors(6, NVEC - 1, 1'b0);

        // Fill the pipeline with nonzero products, then reset mid-stream.
        for (int n = 0; n < 3; n++) begin
            a = vec_a[1 + n];
            b = vec_b[1 + n];
            @(posedge clk);
            #1;
        end
        check("pre_reset_out", out, vec_p[1]);
        rst_n = 1'b0;
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        #1;
        check("async_reset", out, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", out, 32'd0);
        rst_n = 1'b1;
        // In-flight pairs must be gone: zeros until 1.0*1.0 arrives.
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_e%0d", n), out, (n == 2) ? 32'h3F800000 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
